// File: rtl/iob_native_sram_resp_pkg.sv
// Shared definitions for the native-bus SRAM responder: FSM encodings and wait-counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package iob_native_sram_resp_pkg;

    // Wide enough for WAIT_STATES up to 15.
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Counter preload that yields exactly ws cycles spent in WAIT.
    function automatic logic [WAIT_CNT_W-1:0] wait_load(input int ws);
        return (ws > 0) ? WAIT_CNT_W'(ws - 1) : '0;
    endfunction

endpackage

// File: rtl/iob_ram_sp_be.sv
// Synchronous single-port RAM with per-byte write enables; contents are never reset.
// Latency: dout valid one cycle after an enabled access (read-before-write on a write access).
// Backpressure: none; accepts an access every cycle that en is high.
// Ports: clk, en (access strobe), we (byte enables), addr (word index), din, dout.
module iob_ram_sp_be #(
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 12
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic [DATA_W/8-1:0]     we,
    input  logic [MEM_ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]       din,
    output logic [DATA_W-1:0]       dout
);

    logic [DATA_W-1:0] r_mem [0:(2**MEM_ADDR_W)-1];
    logic [DATA_W-1:0] r_dout;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (we[i]) begin
                    r_mem[addr][i*8 +: 8] <= din[i*8 +: 8];
                end
            end
            r_dout <= r_mem[addr];
        end
    end

    assign dout = r_dout;

endmodule

// File: rtl/iob_native_sram_resp.sv
// Native valid/ready responder serving one request at a time from a byte-enabled SRAM.
// Latency: valid sampled in cycle N -> one-cycle ready in cycle N+2+WAIT_STATES; 3+WAIT_STATES cycles/access.
// Backpressure: none toward the initiator beyond withholding ready; valid is ignored outside IDLE.
// Ports: clk, resetn (async active-low), req {valid,address,wdata,wstrb}, resp {rdata,ready}.
// Optional: IOB_NATIVE_SRAM_RESP_WPROT_EN adds input wprot; when high in ACCESS, writes are acked but dropped.
module iob_native_sram_resp
    import iob_native_sram_resp_pkg::*;
#(
    parameter  int DATA_W      = 32,
    parameter  int ADDR_W      = 32,
    parameter  int MEM_ADDR_W  = 12,
    parameter  int WAIT_STATES = 0,
    localparam int STRB_W      = DATA_W / 8,
    localparam int REQ_W       = 1 + ADDR_W + DATA_W + STRB_W,
    localparam int RESP_W      = DATA_W + 1
) (
    input  logic              clk,
    input  logic              resetn,
`ifdef IOB_NATIVE_SRAM_RESP_WPROT_EN
    input  logic              wprot,
`endif
    input  logic [REQ_W-1:0]  req,
    output logic [RESP_W-1:0] resp
);

    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = wait_load(WAIT_STATES);

    // Request field extraction: {valid, address, wdata, wstrb}.
    logic                  w_valid;
    logic [ADDR_W-1:0]     w_addr;
    logic [DATA_W-1:0]     w_wdata;
    logic [STRB_W-1:0]     w_wstrb;
    logic                  w_unused_addr;

    assign w_valid = req[REQ_W-1];
    assign w_addr  = req[REQ_W-2 -: ADDR_W];
    assign w_wdata = req[STRB_W +: DATA_W];
    assign w_wstrb = req[0 +: STRB_W];
    // Upper and byte-offset address bits are deliberately ignored (aliasing).
    assign w_unused_addr = ^w_addr;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [MEM_ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  r_ready;
    logic [DATA_W-1:0]     r_rdata;

    logic                  w_ram_en;
    logic [STRB_W-1:0]     w_ram_we;
    logic [DATA_W-1:0]     w_ram_dout;
    logic                  w_wr_allow;
    logic                  w_rd_resp;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_state_nxt = (WAIT_STATES > 0) ? WAIT : ACCESS;
            WAIT:    if (r_cnt == '0) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Ready comes straight from a flop so the initiator's valid-gating cannot loop back.
            r_ready <= (r_state == ACCESS);
            if (r_state == IDLE && w_valid) begin
                r_addr  <= w_addr[MEM_ADDR_W+1:2];
                r_wdata <= w_wdata;
                r_wstrb <= w_wstrb;
                r_cnt   <= CNT_LOAD;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - WAIT_CNT_W'(1);
            end
            if (w_rd_resp) begin
                r_rdata <= w_ram_dout;
            end
        end
    end

`ifdef IOB_NATIVE_SRAM_RESP_WPROT_EN
    assign w_wr_allow = ~wprot;
`else
    assign w_wr_allow = 1'b1;
`endif

    // The SRAM is only touched in ACCESS, so a reset before then can never corrupt memory.
    assign w_ram_en  = (r_state == ACCESS);
    assign w_ram_we  = (w_ram_en && w_wr_allow) ? r_wstrb : '0;
    assign w_rd_resp = (r_state == RESP) && (r_wstrb == '0);

    iob_ram_sp_be #(
        .DATA_W     (DATA_W),
        .MEM_ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk  (clk),
        .en   (w_ram_en),
        .we   (w_ram_we),
        .addr (r_addr),
        .din  (r_wdata),
        .dout (w_ram_dout)
    );

    // Read data is presented from the RAM output register in the RESP cycle, then held.
    assign resp = {(w_rd_resp ? w_ram_dout : r_rdata), r_ready};

endmodule

// File: tb/tb_iob_native_sram_resp.sv
module tb_iob_native_sram_resp;

    localparam int REQ_W  = 69;
    localparam int RESP_W = 33;

    typedef struct {
        logic [31:0] rdata;
        int          due;
    } exp_t;

    logic              clk = 1'b0;
    logic              resetn0 = 1'b0;
    logic              resetn1 = 1'b0;
    logic [REQ_W-1:0]  req0 = '0;
    logic [REQ_W-1:0]  req1 = '0;
    logic [RESP_W-1:0] resp0;
    logic [RESP_W-1:0] resp1;
`ifdef IOB_NATIVE_SRAM_RESP_WPROT_EN
    logic              wprot0 = 1'b0;
    logic              wprot1 = 1'b0;
`endif

    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] last_rd [2] = '{32'h0, 32'h0};
    logic        prev_rdy [2] = '{1'b0, 1'b0};
    int          ws [2] = '{0, 3};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iob_native_sram_resp #(.DATA_W(32), .ADDR_W(32), .MEM_ADDR_W(12), .WAIT_STATES(0)) dut0 (
        .clk    (clk),
        .resetn (resetn0),
`ifdef IOB_NATIVE_SRAM_RESP_WPROT_EN
        .wprot  (wprot0),
`endif
        .req    (req0),
        .resp   (resp0)
    );

    iob_native_sram_resp #(.DATA_W(32), .ADDR_W(32), .MEM_ADDR_W(12), .WAIT_STATES(3)) dut1 (
        .clk    (clk),
        .resetn (resetn1),
`ifdef IOB_NATIVE_SRAM_RESP_WPROT_EN
        .wprot  (wprot1),
`endif
        .req    (req1),
        .resp   (resp1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic mon_step(input int d, input logic rdy, input logic [31:0] rd);
        exp_t e;
        if (prev_rdy[d]) chk($sformatf("dut%0d_ready_one_cycle", d), {31'b0, rdy}, 32'd0);
        if (rdy) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                chk($sformatf("dut%0d_unexpected_ready", d), 32'd1, 32'd0);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("dut%0d_latency", d), cyc, e.due);
                chk($sformatf("dut%0d_rdata", d), rd, e.rdata);
            end
        end
        prev_rdy[d] = rdy;
    endtask

    // Monitor: decoupled from stimulus, pops an expectation on every ready pulse.
    initial begin
        forever begin
            @(negedge clk);
            mon_step(0, resp0[0], resp0[32:1]);
            mon_step(1, resp1[0], resp1[32:1]);
        end
    end

    // Issue one request and wait for its ready; exp_rd is the expected read word (reads only).
    task automatic do_req(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp_rd, input bit drop);
        exp_t e;
        int   n;
        logic rdy;
        @(negedge clk);
        if (d == 0) req0 = {1'b1, addr, wdata, wstrb};
        else        req1 = {1'b1, addr, wdata, wstrb};
        if (wstrb == 4'h0) last_rd[d] = exp_rd;
        e.rdata = last_rd[d];
        e.due   = cyc + 2 + ws[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        n = 0;
        forever begin
            @(negedge clk);
            if (drop && n == 0) begin
                if (d == 0) req0[REQ_W-1] = 1'b0;
                else        req1[REQ_W-1] = 1'b0;
            end
            rdy = (d == 0) ? resp0[0] : resp1[0];
            if (rdy) break;
            n++;
            if (n > 40) begin
                chk($sformatf("dut%0d_ready_timeout", d), 32'd0, 32'd1);
                break;
            end
        end
        if (d == 0) req0[REQ_W-1] = 1'b0;
        else        req1[REQ_W-1] = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] wp_exp;
        // Reset state of both instances.
        repeat (2) @(negedge clk);
        chk("rst_ready0", {31'b0, resp0[0]}, 32'd0);
        chk("rst_rdata0", resp0[32:1], 32'd0);
        chk("rst_state1", {30'b0, dut1.r_state}, 32'd0);
        resetn0 = 1'b1;
        resetn1 = 1'b1;

        // WAIT_STATES=0: basic write/read, byte lanes, aliasing, valid dropped mid-request.
        do_req(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);
        do_req(0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 0);
        do_req(0, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0, 0);
        do_req(0, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0, 0);
        do_req(0, 32'h0000_0020, 32'h0,         4'h0, 32'h11BB_33DD, 0);
        do_req(0, 32'h0000_4010, 32'hCAFE_F00D, 4'hF, 32'h0, 0);
        do_req(0, 32'h0000_0010, 32'h0,         4'h0, 32'hCAFE_F00D, 0);
        do_req(0, 32'h0000_0050, 32'h55AA_55AA, 4'hF, 32'h0, 1);
        do_req(0, 32'h0000_0050, 32'h0,         4'h0, 32'h55AA_55AA, 0);

        // Write protection: the protected write is acked but must not land when enabled.
        do_req(0, 32'h0000_0040, 32'h0,         4'hF, 32'h0, 0);
`ifdef IOB_NATIVE_SRAM_RESP_WPROT_EN
        wprot0 = 1'b1;
        wp_exp = 32'h0;
`else
        wp_exp = 32'h1234_5678;
`endif
        do_req(0, 32'h0000_0040, 32'h1234_5678, 4'hF, 32'h0, 0);
`ifdef IOB_NATIVE_SRAM_RESP_WPROT_EN
        wprot0 = 1'b0;
`endif
        do_req(0, 32'h0000_0040, 32'h0,         4'h0, wp_exp, 0);

        // WAIT_STATES=3: latency of 5 cycles, then reset in the middle of a write.
        do_req(1, 32'h0000_0020, 32'h0BAD_F00D, 4'hF, 32'h0, 0);
        do_req(1, 32'h0000_0020, 32'h0,         4'h0, 32'h0BAD_F00D, 0);
        do_req(1, 32'h0000_0030, 32'h0,         4'hF, 32'h0, 0);

        @(negedge clk);
        req1 = {1'b1, 32'h0000_0030, 32'h1234_5678, 4'hF};
        repeat (2) @(negedge clk);
        chk("wait_state1", {30'b0, dut1.r_state}, 32'd1);
        #2;
        resetn1 = 1'b0;
        req1[REQ_W-1] = 1'b0;
        last_rd[1] = 32'h0;
        #1;
        chk("arst_ready1", {31'b0, resp1[0]}, 32'd0);
        chk("arst_rdata1", resp1[32:1], 32'd0);
        chk("arst_state1", {30'b0, dut1.r_state}, 32'd0);
        repeat (2) @(negedge clk);
        resetn1 = 1'b1;
        do_req(1, 32'h0000_0030, 32'h0,         4'h0, 32'h0, 0);

        repeat (4) @(negedge clk);
        chk("queue0_empty", q0.size(), 32'd0);
        chk("queue1_empty", q1.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
